ascii_expr_parser: RTL and testbench
====================================

# ascii_expr_parser

Parametrised successor to the calculator input stage. It pops ASCII characters from the UART RX FIFO and parses expressions of the form `<num1> <op> <num2> <term>`, with optional spaces between tokens. It hands the parsed operands and operator to the ALU over a valid/ready handshake and reports syntax, overflow and divide-by-zero errors. Malformed input is resynchronised by discarding characters up to the next terminator.

## Interface
- DATA_WIDTH, 8, RX FIFO character width; only bits [7:0] are decoded, upper bits must be zero.
- NUM_WIDTH, 16, operand width; unsigned decimal range 0 .. 2^NUM_WIDTH-1.

- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data_in  in  DATA_WIDTH  FIFO head character (first-word fall-through), valid when rx_empty_in=0.
- rx_empty_in  in  1  FIFO empty.
- rx_ren_o  out  1  pop strobe; head is consumed at the edge where rx_ren_o=1.
- num1_o  out  NUM_WIDTH  first operand.
- num2_o  out  NUM_WIDTH  second operand.
- operator_o  out  2  '+'=00, '-'=01, '*'=10, '/'=11.
- cmd_valid_o  out  1  parsed command available.
- cmd_ready_in  in  1  ALU accepts command.
- err_valid_o  out  1  one-cycle error pulse.
- err_code_o  out  2  01 syntax, 10 overflow, 11 divide-by-zero; holds the last code.

## Operation
- Character classes:
  - digit: 0x30-0x39
  - op: 0x2B, 0x2D, 0x2A, 0x2F
  - space: 0x20
  - term: '=' 0x3D, CR 0x0D, LF 0x0A
  - anything else: illegal
- rx_ren_o = !rx_empty_in in states IDLE, NUM1, OP, N2_START, NUM2, FLUSH; it is 0 in EMIT. rx_ren_o is combinational; no character is ever skipped without being popped.
- States and transitions, per popped character:
  - IDLE: space or term → stay. Digit → acc=d, go NUM1. Else → SYNTAX error.
  - NUM1: digit → acc=acc*10+d. Space → OP. Op → latch op, num1=acc, go N2_START. Else → SYNTAX.
  - OP: space → stay. Op → latch op, num1=acc, go N2_START. Else → SYNTAX.
  - N2_START: space → stay. Digit → acc=d, go NUM2. Else → SYNTAX.
  - NUM2: digit → accumulate. Space or term → num2=acc, then:
    - if op='/' and acc==0 → DIV_ZERO error, go to IDLE (term) or FLUSH (space);
    - otherwise go to EMIT.
    - Any other character → SYNTAX.
  - EMIT: cmd_valid_o=1 until cmd_ready_in=1 at a rising edge, then IDLE.
  - FLUSH: pop and discard until a term is popped, then IDLE.
- Error routing: if the offending character is itself a term, go to IDLE; otherwise go to FLUSH.
- Accumulation uses NUM_WIDTH+4 bits. If acc*10+d > 2^NUM_WIDTH-1, raise an OVERFLOW error and go to FLUSH; acc is not updated.
- num1_o, num2_o and operator_o are registered. They are stable whenever cmd_valid_o=1, and change only when latched by a later parse.
- A space after num2 with no further term still emits the command; the following term is then skipped in IDLE.

## Timing
- Reset values: state IDLE, acc 0, num1_o 0, num2_o 0, operator_o 00, cmd_valid_o 0, err_valid_o 0, err_code_o 00. rx_ren_o follows from IDLE: it equals !rx_empty_in.
- Throughput: at most one character per cycle. An empty FIFO mid-number stalls the parse with no state change.
- Command latency: terminator popped at edge T → cmd_valid_o=1 in the cycle after T.
- Handshake: a transfer completes at the edge where cmd_valid_o=1 and cmd_ready_in=1. The parser is in IDLE and may pop in the next cycle. cmd_valid_o never drops without a transfer. The minimum gap between commands is one cycle.
- err_valid_o is registered and high for exactly one cycle after the offending pop edge; err_code_o updates on the same edge.
- rst dominates every input. Reset mid-parse discards the partial expression; characters already popped are lost.

## Test plan
- "12+34\n", cmd_ready_in=1 → num1_o=12, num2_o=34, operator_o=00, cmd_valid_o high for 1 cycle, no err_valid_o.
- " 7 * 6 =" with one empty cycle inside the stream → 7, 6, 10; idle cycle tolerated; exactly one command.
- NUM_WIDTH=16, "70000+1\n5-3\n" → err_valid_o one pulse with code 10, FIFO drained through LF, then command 5, 3, 01.
- "9/0=" → err code 11, no cmd_valid_o. Next "8/2=" → 8, 2, 11.
- "1+2=3+4=" preloaded, cmd_ready_in=0 for 5 cycles → cmd_valid_o held, outputs 1/2/00 stable, rx_ren_o=0. After ready: command 3, 4, 00.
- "+5\nA\n", then assert rst during "12" of "12+3" → syntax errors 01 twice; after reset all outputs 0 and state IDLE; the remaining "+3" produces a syntax error.

Source files
------------

// File: rtl/ascii_expr_parser_if.sv
// Bundles the RX FIFO pop port, the ALU command handshake and the error report
// of the ASCII expression parser; master is the parser side.
interface ascii_expr_parser_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] rx_data_in;
    logic                  rx_empty_in;
    logic                  rx_ren_o;
    logic [NUM_WIDTH-1:0]  num1_o;
    logic [NUM_WIDTH-1:0]  num2_o;
    logic [1:0]            operator_o;
    logic                  cmd_valid_o;
    logic                  cmd_ready_in;
    logic                  err_valid_o;
    logic [1:0]            err_code_o;

    modport master (
        input  rx_data_in, rx_empty_in, cmd_ready_in,
        output rx_ren_o, num1_o, num2_o, operator_o,
               cmd_valid_o, err_valid_o, err_code_o
    );

    modport slave (
        output rx_data_in, rx_empty_in, cmd_ready_in,
        input  rx_ren_o, num1_o, num2_o, operator_o,
               cmd_valid_o, err_valid_o, err_code_o
    );
endinterface

// File: rtl/ascii_expr_parser.sv
// Pops ASCII characters from a FWFT FIFO, parses "<num1> <op> <num2> <term>"
// and hands operands/operator to the ALU; bad input is flushed up to a terminator.
module ascii_expr_parser #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WIDTH  = 16
) (
    input logic                clk,
    input logic                rst,
    ascii_expr_parser_if.master bus
);
    localparam int ACC_W = NUM_WIDTH + 4;
    localparam logic [ACC_W-1:0] NUM_MAX = {4'b0000, {NUM_WIDTH{1'b1}}};
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_NUM1, S_OP, S_N2_START, S_NUM2, S_EMIT, S_FLUSH
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_SYNTAX   = 2'b01,
        ERR_OVERFLOW = 2'b10,
        ERR_DIV_ZERO = 2'b11
    } err_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [NUM_WIDTH-1:0] num1_q, num1_d, num2_q, num2_d;
    logic [1:0]           op_q, op_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic                 err_valid_q, err_valid_d;
    logic [1:0]           err_code_q, err_code_d;

    logic [7:0]       ch;
    logic             upper_zero;
    logic             is_digit, is_op, is_space, is_term;
    logic [3:0]       digit;
    logic [1:0]       op_code;
    logic [ACC_W-1:0] acc_mac;
    logic             acc_ovf;
    logic             pop;
    logic             raise;
    err_t             raise_code;

    assign ch = bus.rx_data_in[7:0];

    if (DATA_WIDTH > 8) begin : g_wide
        assign upper_zero = ~|bus.rx_data_in[DATA_WIDTH-1:8];
    end else begin : g_narrow
        assign upper_zero = 1'b1;
    end

    assign is_digit = upper_zero && (ch >= 8'h30) && (ch <= 8'h39);
    assign is_op    = upper_zero && (ch == 8'h2B || ch == 8'h2D || ch == 8'h2A || ch == 8'h2F);
    assign is_space = upper_zero && (ch == 8'h20);
    assign is_term  = upper_zero && (ch == 8'h3D || ch == 8'h0D || ch == 8'h0A);
    assign digit    = ch[3:0];

    always_comb begin
        unique case (ch)
            8'h2D:   op_code = 2'b01;
            8'h2A:   op_code = 2'b10;
            8'h2F:   op_code = 2'b11;
            default: op_code = 2'b00;
        endcase
    end

    // acc*10 + d; ACC_W holds the worst case (2^NUM_WIDTH-1)*10+9 without wrap.
    assign acc_mac = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit);
    assign acc_ovf = acc_mac > NUM_MAX;

    // The pop strobe is combinational so a character can be consumed every cycle.
    assign pop = !bus.rx_empty_in && (state_q != S_EMIT);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        op_d        = op_q;
        cmd_valid_d = cmd_valid_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        raise       = 1'b0;
        raise_code  = ERR_SYNTAX;

        unique case (state_q)
            S_IDLE: if (pop) begin
                if (is_digit) begin
                    acc_d   = ACC_W'(digit);
                    state_d = S_NUM1;
                end else if (!(is_space || is_term)) begin
                    raise = 1'b1;
                end
            end
            S_NUM1: if (pop) begin
                if (is_digit) begin
                    if (acc_ovf) begin
                        raise      = 1'b1;
                        raise_code = ERR_OVERFLOW;
                    end else begin
                        acc_d = acc_mac;
                    end
                end else if (is_space) begin
                    state_d = S_OP;
                end else if (is_op) begin
                    op_d    = op_code;
                    num1_d  = acc_q[NUM_WIDTH-1:0];
                    state_d = S_N2_START;
                end else begin
                    raise = 1'b1;
                end
            end
            S_OP: if (pop) begin
                if (is_op) begin
                    op_d    = op_code;
                    num1_d  = acc_q[NUM_WIDTH-1:0];
                    state_d = S_N2_START;
                end else if (!is_space) begin
                    raise = 1'b1;
                end
            end
            S_N2_START: if (pop) begin
                if (is_digit) begin
                    acc_d   = ACC_W'(digit);
                    state_d = S_NUM2;
                end else if (!is_space) begin
                    raise = 1'b1;
                end
            end
            S_NUM2: if (pop) begin
                if (is_digit) begin
                    if (acc_ovf) begin
                        raise      = 1'b1;
                        raise_code = ERR_OVERFLOW;
                    end else begin
                        acc_d = acc_mac;
                    end
                end else if (is_space || is_term) begin
                    num2_d = acc_q[NUM_WIDTH-1:0];
                    if (op_q == OP_DIV && acc_q == '0) begin
                        raise      = 1'b1;
                        raise_code = ERR_DIV_ZERO;
                    end else begin
                        cmd_valid_d = 1'b1;
                        state_d     = S_EMIT;
                    end
                end else begin
                    raise = 1'b1;
                end
            end
            S_EMIT: if (bus.cmd_ready_in) begin
                cmd_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            S_FLUSH: if (pop && is_term) begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A terminator that is itself the offending character already ends the line.
        if (raise) begin
            err_valid_d = 1'b1;
            err_code_d  = raise_code;
            state_d     = is_term ? S_IDLE : S_FLUSH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            op_q        <= 2'b00;
            cmd_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q     <= state_d;
            acc_q       <= acc_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            op_q        <= op_d;
            cmd_valid_q <= cmd_valid_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.rx_ren_o    = pop;
    assign bus.num1_o      = num1_q;
    assign bus.num2_o      = num2_q;
    assign bus.operator_o  = op_q;
    assign bus.cmd_valid_o = cmd_valid_q;
    assign bus.err_valid_o = err_valid_q;
    assign bus.err_code_o  = err_code_q;
endmodule

// File: tb/tb_ascii_expr_parser.sv
// Bench for ascii_expr_parser: a grammar-level reference model turns each
// character string into the expected command/error sequence, checked every cycle.
module tb_ascii_expr_parser;
    localparam int     DATA_WIDTH = 8;
    localparam int     NUM_WIDTH  = 16;
    localparam longint NUM_MAX    = (64'd1 << NUM_WIDTH) - 1;

    typedef struct {
        bit     is_err;
        int     code;
        longint n1;
        longint n2;
        int     op;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ascii_expr_parser_if #(.DATA_WIDTH(DATA_WIDTH), .NUM_WIDTH(NUM_WIDTH)) bus ();

    ascii_expr_parser #(.DATA_WIDTH(DATA_WIDTH), .NUM_WIDTH(NUM_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    ev_t        exp_q[$];
    logic [8:0] fifo[$];   // bit 8 marks a one-cycle empty bubble
    int         total = 0;
    int         bad = 0;
    int         stall_pct = 0;
    bit         rand_ready = 1'b0;
    bit         ready_level = 1'b1;
    int         cmd_cnt = 0, err_cnt = 0, vcycles = 0;
    longint     last_n1 = 0, last_n2 = 0;
    int         last_op = 0, last_err = 0;
    int         m_cmd, m_err, m_v;

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_digit_c(input byte c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction
    function automatic bit is_op_c(input byte c);
        return c == 8'h2B || c == 8'h2D || c == 8'h2A || c == 8'h2F;
    endfunction
    function automatic bit is_term_c(input byte c);
        return c == 8'h3D || c == 8'h0D || c == 8'h0A;
    endfunction
    function automatic int op_of(input byte c);
        if (c == 8'h2B) return 0;
        if (c == 8'h2D) return 1;
        if (c == 8'h2A) return 2;
        return 3;
    endfunction

    function automatic void exp_err(input int code);
        ev_t e;
        e = '{is_err: 1'b1, code: code, n1: 0, n2: 0, op: 0};
        exp_q.push_back(e);
    endfunction
    function automatic void exp_cmd(input longint n1, input longint n2, input int op);
        ev_t e;
        e = '{is_err: 1'b0, code: 0, n1: n1, n2: n2, op: op};
        exp_q.push_back(e);
    endfunction

    function automatic void flush_line(input string s, inout int i);
        byte c;
        while (i < s.len()) begin
            c = s[i];
            i++;
            if (is_term_c(c)) return;
        end
    endfunction

    function automatic void syntax(input byte c, input string s, inout int i);
        exp_err(1);
        if (!is_term_c(c)) flush_line(s, i);
    endfunction

    // st: 0 = ran out of input, 1 = stopped on non-digit c, 2 = digit c overflows
    function automatic void read_num(input string s, inout int i, inout longint a,
                                     output byte c, output int st);
        st = 0;
        c  = 0;
        while (i < s.len()) begin
            c = s[i];
            i++;
            if (!is_digit_c(c)) begin
                st = 1;
                return;
            end
            if (a * 10 + (c - 48) > NUM_MAX) begin
                st = 2;
                return;
            end
            a = a * 10 + (c - 48);
        end
    endfunction

    function automatic bit next_nonspace(input string s, inout int i, output byte c);
        c = 0;
        while (i < s.len()) begin
            c = s[i];
            i++;
            if (c != 8'h20) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_run(input string s);
        int     i = 0;
        int     st, op;
        byte    c;
        longint a, n1;
        while (i < s.len()) begin
            c = s[i];
            i++;
            if (c == 8'h20 || is_term_c(c)) continue;
            if (!is_digit_c(c)) begin syntax(c, s, i); continue; end
            a = c - 48;
            read_num(s, i, a, c, st);
            if (st == 0) return;
            if (st == 2) begin exp_err(2); flush_line(s, i); continue; end
            if (c == 8'h20) begin
                if (!next_nonspace(s, i, c)) return;
            end
            if (!is_op_c(c)) begin syntax(c, s, i); continue; end
            op = op_of(c);
            n1 = a;
            if (!next_nonspace(s, i, c)) return;
            if (!is_digit_c(c)) begin syntax(c, s, i); continue; end
            a = c - 48;
            read_num(s, i, a, c, st);
            if (st == 0) return;
            if (st == 2) begin exp_err(2); flush_line(s, i); continue; end
            if (!(c == 8'h20 || is_term_c(c))) begin syntax(c, s, i); continue; end
            if (op == 3 && a == 0) begin
                exp_err(3);
                if (c == 8'h20) flush_line(s, i);
                continue;
            end
            exp_cmd(n1, a, op);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input string s, input int bubble_at = -1);
        for (int k = 0; k < s.len(); k++) begin
            if (k == bubble_at) fifo.push_back(9'h100);
            fifo.push_back({1'b0, s[k]});
        end
        model_run(s);
    endtask

    task automatic mark();
        m_cmd = cmd_cnt;
        m_err = err_cnt;
        m_v   = vcycles;
    endtask

    task automatic drain(input int budget);
        int idle = 0;
        int n = 0;
        while (idle < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (fifo.size() == 0 && !bus.cmd_valid_o && !bus.err_valid_o) idle++;
            else idle = 0;
        end
        check("drain_completed", idle >= 3, 1);
        check("no_missing_events", exp_q.size(), 0);
    endtask

    function automatic string rand_num();
        int r = $urandom_range(0, 9);
        if (r == 0) return $sformatf("%0d", $urandom_range(60000, 99999));
        if (r == 1) return "0";
        return $sformatf("%0d", $urandom_range(0, 999));
    endfunction

    function automatic string sp();
        return ($urandom_range(0, 3) == 0) ? " " : "";
    endfunction

    function automatic string rand_line();
        string ops   = "+-*/";
        string terms = "=\015\n";
        string junk  = "0123456789+-*/ =A\n";
        string s     = "";
        byte   t;
        t = terms[$urandom_range(0, 2)];
        if ($urandom_range(0, 3) != 0) begin
            s = $sformatf("%s%s%s%c%s%s%s%c", sp(), rand_num(), sp(),
                          ops[$urandom_range(0, 3)], sp(), rand_num(), sp(), t);
        end else begin
            for (int k = 0; k < $urandom_range(1, 6); k++)
                s = {s, $sformatf("%c", junk[$urandom_range(0, junk.len() - 1)])};
            s = {s, $sformatf("%c", t)};
        end
        return s;
    endfunction

    // ---------------- FIFO / ready driver ----------------
    initial begin
        bit popped;
        bus.rx_empty_in  = 1'b1;
        bus.rx_data_in   = '0;
        bus.cmd_ready_in = 1'b0;
        forever begin
            @(negedge clk);
            popped = bus.rx_ren_o && !bus.rx_empty_in && !rst;
            @(posedge clk);
            #1;
            if (popped) void'(fifo.pop_front());
            bus.cmd_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
            if (fifo.size() > 0 && fifo[0][8]) begin
                void'(fifo.pop_front());
                bus.rx_empty_in = 1'b1;
            end else if (rst || fifo.size() == 0 || $urandom_range(0, 99) < stall_pct) begin
                bus.rx_empty_in = 1'b1;
            end else begin
                bus.rx_empty_in = 1'b0;
                bus.rx_data_in  = fifo[0][7:0];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        bit                   hold = 1'b0;
        logic [NUM_WIDTH-1:0] h1 = '0, h2 = '0;
        logic [1:0]           hop = '0;
        ev_t                  ev;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (bus.cmd_valid_o) check("ren_low_while_valid", bus.rx_ren_o, 0);
                else                 check("ren_follows_empty", bus.rx_ren_o, !bus.rx_empty_in);
                if (hold) begin
                    check("valid_held", bus.cmd_valid_o, 1);
                    check("num1_stable", bus.num1_o, h1);
                    check("num2_stable", bus.num2_o, h2);
                    check("op_stable", bus.operator_o, hop);
                end
                if (bus.cmd_valid_o) vcycles++;
                if (bus.cmd_valid_o && bus.cmd_ready_in) begin
                    cmd_cnt++;
                    last_n1 = bus.num1_o;
                    last_n2 = bus.num2_o;
                    last_op = bus.operator_o;
                    check("cmd_was_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        ev = exp_q.pop_front();
                        check("event_is_cmd", ev.is_err, 0);
                        check("num1", bus.num1_o, ev.n1);
                        check("num2", bus.num2_o, ev.n2);
                        check("operator", bus.operator_o, ev.op);
                    end
                end
                if (bus.err_valid_o) begin
                    err_cnt++;
                    last_err = bus.err_code_o;
                    check("err_was_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        ev = exp_q.pop_front();
                        check("event_is_err", ev.is_err, 1);
                        check("err_code", bus.err_code_o, ev.code);
                    end
                end
                hold = bus.cmd_valid_o && !bus.cmd_ready_in;
                h1   = bus.num1_o;
                h2   = bus.num2_o;
                hop  = bus.operator_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        string s;
        int    n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_num1", bus.num1_o, 0);
        check("rst_num2", bus.num2_o, 0);
        check("rst_op", bus.operator_o, 0);
        check("rst_cmd_valid", bus.cmd_valid_o, 0);
        check("rst_err_valid", bus.err_valid_o, 0);
        check("rst_err_code", bus.err_code_o, 0);
        check("rst_ren_empty", bus.rx_ren_o, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // basic command with ready held high
        mark();
        send("12+34\n");
        drain(200);
        check("t1_cmds", cmd_cnt - m_cmd, 1);
        check("t1_errs", err_cnt - m_err, 0);
        check("t1_valid_cycles", vcycles - m_v, 1);
        check("t1_num1", last_n1, 12);
        check("t1_num2", last_n2, 34);
        check("t1_op", last_op, 0);

        // spaces and an empty cycle mid-stream
        mark();
        send(" 7 * 6 =", 3);
        drain(200);
        check("t2_cmds", cmd_cnt - m_cmd, 1);
        check("t2_num1", last_n1, 7);
        check("t2_num2", last_n2, 6);
        check("t2_op", last_op, 2);

        // overflow, flush through LF, then a good command
        mark();
        send("70000+1\n5-3\n");
        drain(200);
        check("t3_errs", err_cnt - m_err, 1);
        check("t3_code", last_err, 2);
        check("t3_cmds", cmd_cnt - m_cmd, 1);
        check("t3_num1", last_n1, 5);
        check("t3_num2", last_n2, 3);
        check("t3_op", last_op, 1);

        // divide by zero, then a legal divide
        mark();
        send("9/0=");
        drain(200);
        check("t4_errs", err_cnt - m_err, 1);
        check("t4_code", last_err, 3);
        check("t4_cmds", cmd_cnt - m_cmd, 0);
        mark();
        send("8/2=");
        drain(200);
        check("t4b_num1", last_n1, 8);
        check("t4b_num2", last_n2, 2);
        check("t4b_op", last_op, 3);

        // back-pressure: command held while the ALU is not ready
        @(negedge clk);
        ready_level = 1'b0;
        repeat (2) @(negedge clk);
        mark();
        send("1+2=3+4=");
        n = 0;
        while (!bus.cmd_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_valid_seen", bus.cmd_valid_o, 1);
        repeat (5) @(negedge clk);
        check("t5_valid_still", bus.cmd_valid_o, 1);
        check("t5_num1", bus.num1_o, 1);
        check("t5_num2", bus.num2_o, 2);
        check("t5_op", bus.operator_o, 0);
        check("t5_no_pop", bus.rx_ren_o, 0);
        check("t5_fifo_left", fifo.size(), 4);
        ready_level = 1'b1;
        drain(200);
        check("t5_cmds", cmd_cnt - m_cmd, 2);
        check("t5b_num1", last_n1, 3);
        check("t5b_num2", last_n2, 4);
        check("t5b_op", last_op, 0);

        // syntax errors, then reset in the middle of a number
        mark();
        send("+5\nA\n");
        drain(200);
        check("t6_errs", err_cnt - m_err, 2);
        check("t6_code", last_err, 1);
        send("12");
        drain(200);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("t6_rst_num1", bus.num1_o, 0);
        check("t6_rst_num2", bus.num2_o, 0);
        check("t6_rst_op", bus.operator_o, 0);
        check("t6_rst_valid", bus.cmd_valid_o, 0);
        check("t6_rst_err_valid", bus.err_valid_o, 0);
        check("t6_rst_err_code", bus.err_code_o, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        mark();
        send("+3\n");
        drain(200);
        check("t6b_errs", err_cnt - m_err, 1);
        check("t6b_code", last_err, 1);
        check("t6b_cmds", cmd_cnt - m_cmd, 0);
        check("t6b_num1_untouched", bus.num1_o, 0);

        // randomized stream with FIFO stalls and random ALU back-pressure
        stall_pct  = 30;
        rand_ready = 1'b1;
        s = "";
        for (int l = 0; l < 60; l++) s = {s, rand_line()};
        send(s);
        drain(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
